// File: rtl/keccak_pkg.sv
// Shared Keccak constants, mode encodings and squeeze FSM types.
// EndianSwitcher reverses byte order within one lane.
package keccak_pkg;

  localparam int w = 64;
  localparam int RATE_SHAKE128 = 1344;

  localparam logic [1:0] SHAKE128_MODE_VEC = 2'b10;
  localparam logic [1:0] SHAKE256_MODE_VEC = 2'b11;

  localparam int DEPTH_SHAKE128 = 21;
  localparam int DEPTH_SHAKE256 = 17;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLOCK,
    SEND
  } squeeze_state_e;

  function automatic logic [w-1:0] EndianSwitcher(
    input logic [w-1:0] x
  );
    logic [w-1:0] y;
    y = '0;
    for (int i = 0; i < w / 8; i++) begin
      y[8*i +: 8] = x[w-8-8*i +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/piso_buffer.sv
// Parallel-in serial-out word buffer; word 0 of the loaded
// block is the head, each shift moves the next word to the head.
module piso_buffer
  import keccak_pkg::*;
#(
  parameter int WIDTH = w,
  parameter int DEPTH = RATE_SHAKE128 / w
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   shift,
  input  logic [WIDTH*DEPTH-1:0] par_in,
  output logic [WIDTH-1:0]       head
);

  logic [WIDTH*DEPTH-1:0] mem_q;
  logic [WIDTH*DEPTH-1:0] mem_d;

  always_comb begin
    mem_d = mem_q;
    if (load) begin
      mem_d = par_in;
    end else if (shift) begin
      mem_d = mem_q >> WIDTH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign head = mem_q[WIDTH-1:0];

endmodule

// File: rtl/squeeze_unloader.sv
// Streams squeezed rate blocks out as big-endian words,
// fetching further blocks until the requested bit count is sent.
module squeeze_unloader
  import keccak_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  input  logic [1:0]               operation_mode,
  input  logic [31:0]              output_size,
  input  logic [RATE_SHAKE128-1:0] rate_output,
  input  logic                     block_valid,
  output logic                     block_ready,
  output logic [w-1:0]             data_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic                     data_out_last,
  output logic                     squeeze_done,
  output logic                     busy
);

  squeeze_state_e state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [31:0]    rem_q, rem_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           done_q, done_d;

  logic           load;
  logic           shift;
  logic [w-1:0]   head;
  logic [w-1:0]   swapped;
  logic [w-1:0]   mask;
  logic [3:0]     nbytes;
  logic [4:0]     depth_m1;
  logic           last_word;

  piso_buffer #(
    .WIDTH(w),
    .DEPTH(RATE_SHAKE128 / w)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .par_in(rate_output),
    .head  (head)
  );

  assign depth_m1 = (mode_q == SHAKE256_MODE_VEC)
                  ? 5'(DEPTH_SHAKE256 - 1)
                  : 5'(DEPTH_SHAKE128 - 1);

  assign last_word = (rem_q <= 32'd64);
  assign nbytes    = rem_q[6:3];
  assign swapped   = EndianSwitcher(head);

  // Keep only the leading valid bytes of a short final word.
  always_comb begin
    mask = '1;
    if (last_word && nbytes != 4'd0) begin
      mask = ~({w{1'b1}} >> {nbytes, 3'b000});
    end
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    rem_d          = rem_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    load           = 1'b0;
    shift          = 1'b0;
    block_ready    = 1'b0;
    data_out_valid = 1'b0;
    data_out_last  = 1'b0;
    data_out       = '0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (output_size != 32'd0) begin
            mode_d  = operation_mode;
            rem_d   = output_size;
            state_d = WAIT_BLOCK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_BLOCK: begin
        block_ready = 1'b1;
        if (block_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        data_out_valid = 1'b1;
        data_out_last  = last_word;
        data_out       = swapped & mask;
        if (data_out_ready) begin
          shift = 1'b1;
          cnt_d = cnt_q + 5'd1;
          rem_d = (rem_q > 32'd64) ? rem_q - 32'd64 : '0;
          if (last_word) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (cnt_q == depth_m1) begin
            state_d = WAIT_BLOCK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign squeeze_done = done_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_squeeze_unloader.sv
// Directed table-driven bench for squeeze_unloader.
// Lane i of block b is 0x0102030405060708 + i + (b << 32).
module tb_squeeze_unloader;
  import keccak_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cfg_valid;
  logic [1:0]               operation_mode;
  logic [31:0]              output_size;
  logic [RATE_SHAKE128-1:0] rate_output;
  logic                     block_valid;
  logic                     block_ready;
  logic [63:0]              data_out;
  logic                     data_out_valid;
  logic                     data_out_ready;
  logic                     data_out_last;
  logic                     squeeze_done;
  logic                     busy;

  always #5 clk = ~clk;

  squeeze_unloader dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .operation_mode(operation_mode),
    .output_size   (output_size),
    .rate_output   (rate_output),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .data_out_last (data_out_last),
    .squeeze_done  (squeeze_done),
    .busy          (busy)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] size;
    logic [63:0] l3;
    bit          stall;
    int          exp_words;
    int          exp_blocks;
    logic [63:0] exp_last;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_fail = 0;
  int          blk;
  logic [63:0] l3_ovr;

  function automatic logic [63:0] lane_val(int b, int i);
    if (b == 0 && i == 3 && l3_ovr != 64'd0) return l3_ovr;
    return 64'h0102030405060708 + 64'(i) + (64'(b) << 32);
  endfunction

  function automatic logic [63:0] model_word(
    logic [63:0] lane, logic [31:0] rem
  );
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      if (rem >= 32'd64 || j < int'(rem / 8))
        y[63-8*j -: 8] = lane[8*j +: 8];
    end
    return y;
  endfunction

  task automatic set_block();
    for (int i = 0; i < 21; i++)
      rate_output[64*i +: 64] = lane_val(blk, i);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_block_ready"}, 64'(block_ready), 64'd0);
    chk({tag, "_valid"}, 64'(data_out_valid), 64'd0);
    chk({tag, "_last"}, 64'(data_out_last), 64'd0);
    chk({tag, "_done"}, 64'(squeeze_done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_data"}, data_out, 64'd0);
  endtask

  task automatic run_vec(int k);
    vec_t        v;
    int          g;
    int          cyc;
    int          depth;
    int          stall_left;
    bit          done_seen;
    bit          rdy;
    bit          prev_last_hs;
    bit          prev_stall;
    bit          prev_load;
    logic [63:0] prev_data;
    logic        prev_lastf;
    logic [63:0] last_data;
    logic [63:0] exp;
    v = vecs[k];
    g = 0;
    cyc = 0;
    depth = (v.mode == SHAKE256_MODE_VEC) ? 17 : 21;
    stall_left = v.stall ? 3 : 0;
    done_seen = 0;
    prev_last_hs = 0;
    prev_stall = 0;
    prev_load = 0;
    prev_data = '0;
    prev_lastf = 1'b0;
    last_data = '0;
    l3_ovr = v.l3;
    blk = 0;
    set_block();
    @(negedge clk);
    cfg_valid = 1'b1;
    operation_mode = v.mode;
    output_size = v.size;
    block_valid = 1'b1;
    data_out_ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    while (!done_seen && cyc < 400) begin
      if (squeeze_done) begin
        chk($sformatf("v%0d_done_after_last", k),
            64'(prev_last_hs), 64'd1);
        chk($sformatf("v%0d_idle_at_done", k), 64'(busy), 64'd0);
        done_seen = 1;
      end else begin
        chk($sformatf("v%0d_busy", k), 64'(busy), 64'd1);
        if (prev_load) begin
          chk($sformatf("v%0d_valid_after_load", k),
              64'(data_out_valid), 64'd1);
          blk++;
          set_block();
        end
        if (prev_stall) begin
          chk($sformatf("v%0d_stall_valid", k),
              64'(data_out_valid), 64'd1);
          chk($sformatf("v%0d_stall_data", k), data_out, prev_data);
          chk($sformatf("v%0d_stall_last", k),
              64'(data_out_last), 64'(prev_lastf));
        end
        rdy = !(v.stall && g == 2 && stall_left > 0);
        if (!rdy) stall_left--;
        data_out_ready = rdy;
        prev_load = block_ready && block_valid;
        prev_stall = data_out_valid && !rdy;
        prev_data = data_out;
        prev_lastf = data_out_last;
        prev_last_hs = 0;
        if (data_out_valid && rdy && g < 64) begin
          exp = model_word(lane_val(g / depth, g % depth),
                           v.size - 32'(64 * g));
          chk($sformatf("v%0d_word%0d", k, g), data_out, exp);
          chk($sformatf("v%0d_last%0d", k, g), 64'(data_out_last),
              64'(g == v.exp_words - 1));
          prev_last_hs = data_out_last;
          if (data_out_last) last_data = data_out;
          g++;
        end
      end
      if (!done_seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!done_seen) chk($sformatf("v%0d_timeout", k), 64'd0, 64'd1);
    chk($sformatf("v%0d_words", k), 64'(g), 64'(v.exp_words));
    chk($sformatf("v%0d_blocks", k), 64'(blk), 64'(v.exp_blocks));
    chk($sformatf("v%0d_last_word", k), last_data, v.exp_last);
    data_out_ready = 1'b1;
  endtask

  initial begin
    int hs;
    int cyc;
    vecs[0] = '{SHAKE128_MODE_VEC, 32'd256, 64'd0, 1'b0, 4, 1,
                64'h0B07060504030201};
    vecs[1] = '{SHAKE256_MODE_VEC, 32'd1152, 64'd0, 1'b1, 18, 2,
                64'h0807060505030201};
    vecs[2] = '{SHAKE128_MODE_VEC, 32'd200, 64'h00000000000000AB,
                1'b0, 4, 1, 64'hAB00000000000000};
    vecs[3] = '{SHAKE128_MODE_VEC, 32'd64, 64'd0, 1'b0, 1, 1,
                64'h0807060504030201};
    vecs[4] = '{SHAKE128_MODE_VEC, 32'd1408, 64'd0, 1'b0, 22, 2,
                64'h0807060505030201};
    vecs[5] = '{2'b01, 32'd1352, 64'd0, 1'b0, 22, 2,
                64'h0800000000000000};
    vecs[6] = '{SHAKE256_MODE_VEC, 32'd24, 64'd0, 1'b0, 1, 1,
                64'h0807060000000000};
    vecs[7] = '{SHAKE128_MODE_VEC, 32'd128, 64'd0, 1'b0, 2, 1,
                64'h0907060504030201};

    rst = 1'b1;
    cfg_valid = 1'b0;
    operation_mode = SHAKE128_MODE_VEC;
    output_size = '0;
    block_valid = 1'b0;
    data_out_ready = 1'b1;
    l3_ovr = '0;
    blk = 0;
    set_block();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(k);

    // Zero-length request: immediate done, no block fetched.
    @(negedge clk);
    cfg_valid = 1'b1;
    output_size = 32'd0;
    block_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("zero_done", 64'(squeeze_done), 64'd1);
    chk("zero_block_ready", 64'(block_ready), 64'd0);
    chk("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("zero_done_pulse", 64'(squeeze_done), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("zero_no_block", 64'(block_ready), 64'd0);
    end

    // Reset in SEND after two words, then a fresh request.
    l3_ovr = '0;
    blk = 0;
    set_block();
    cfg_valid = 1'b1;
    operation_mode = SHAKE128_MODE_VEC;
    output_size = 32'd512;
    data_out_ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    hs = 0;
    cyc = 0;
    while (hs < 2 && cyc < 50) begin
      if (data_out_valid && data_out_ready) hs++;
      @(negedge clk);
      cyc++;
    end
    chk("rst_two_words", 64'(hs), 64'd2);
    chk("rst_in_send", 64'(data_out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_done", 64'(squeeze_done), 64'd0);
    run_vec(7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/squeeze_unloader.md
SQUEEZE_UNLOADER -- requirements
Module: squeeze_unloader

Interface
REQ-001 Parameters: none; w (64), RATE_SHAKE128 (1344) and mode vectors come from keccak_pkg.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cfg_valid  in  1  latch operation_mode/output_size; honoured in IDLE only.
REQ-005 operation_mode  in  2  SHAKE128_MODE_VEC / SHAKE256_MODE_VEC.
REQ-006 output_size  in  32  requested output length in bits, multiple of 8.
REQ-007 rate_output  in  RATE_SHAKE128  squeezed rate block; lane i at bits [64i+63:64i].
REQ-008 block_valid  in  1  rate_output holds a fresh squeezed block.
REQ-009 block_ready  out  1  unloader accepts a block this cycle.
REQ-010 data_out  out  w  output word, big-endian byte order.
REQ-011 data_out_valid  out  1  data_out valid.
REQ-012 data_out_ready  in  1  downstream accepts data_out.
REQ-013 data_out_last  out  1  marks final word of the request.
REQ-014 squeeze_done  out  1  one-cycle pulse when request complete.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 Block depth: SHAKE256 -> 17 words; SHAKE128 and any other mode -> 21 words.
REQ-017 FSM states IDLE, WAIT_BLOCK, SEND; one state per cycle, registered.
REQ-018 IDLE: cfg_valid=1 with output_size!=0 -> latch mode/size, go WAIT_BLOCK; cfg_valid=1 with output_size=0 -> squeeze_done pulse next cycle, stay IDLE, no block consumed.
REQ-019 WAIT_BLOCK: block_ready=1; block_valid=1 loads all lanes into PISO, word counter=0, go SEND; data_out_valid first high the following cycle.
REQ-020 SEND: data_out_valid=1; data_out = byte-reversed lane at PISO head; a handshake (valid&ready) shifts PISO, increments word counter, subtracts 64 from remaining-bit counter (saturating at 0).
REQ-021 SEND without ready: data_out, data_out_last and all state held stable.
REQ-022 Last word: remaining bits <=64; data_out_last=1; bytes beyond remaining_bits[6:3] (when nonzero) zeroed, valid bytes in MSBs (bits 63 downward).
REQ-023 Handshake on last word -> squeeze_done pulse next cycle, go IDLE.
REQ-024 Handshake on word depth-1 (not last) -> go WAIT_BLOCK for next squeezed block; block_ready never asserted in SEND.
REQ-025 block_valid outside WAIT_BLOCK ignored; cfg_valid outside IDLE ignored.
REQ-026 Remaining-bit counter 32 bits; no wrap-around below zero.

Reset
REQ-027 rst: state=IDLE; block_ready, data_out_valid, data_out_last, squeeze_done, busy=0; data_out=0; counters and PISO cleared.
REQ-028 rst mid-request aborts it; no squeeze_done; next cfg_valid starts fresh.

Structure
REQ-029 keccak_pkg gains DEPTH_SHAKE128=21, DEPTH_SHAKE256=17 and the FSM state enum typedef; w, RATE_SHAKE128, mode vectors, EndianSwitcher reused from it.
REQ-030 Sub-module piso_buffer (WIDTH=w, DEPTH=RATE_SHAKE128/w): parallel load, shift-on-enable, head word out; counters may reuse regn/countern.

Verification
REQ-031 SHAKE128, size=256, block lane0..3=0x0102030405060708+k -> 4 words 0x0807060504030201.., last on 4th, squeeze_done, one block consumed.
REQ-032 SHAKE256, size=1152 -> 17 words, block_ready reasserts, second block yields 1 word with last=1.
REQ-033 size=200, lane3=0x00000000000000AB -> 4th word 0xAB00000000000000, last=1.
REQ-034 data_out_ready low 3 cycles mid-block -> data_out/valid stable, no word lost or duplicated.
REQ-035 cfg size=0 -> squeeze_done next cycle, block_ready never high.
REQ-036 rst in SEND after 2 words -> all outputs 0 next cycle; new 128-bit request completes normally.
